// File: rtl/manch_rx.sv
// manch_rx: oversampled Manchester receiver with preamble lock and word output.
// Two states: HUNT qualifies preamble bit intervals until LOCK_BITS are seen,
// then LOCK decodes mid-bit edges into DATA_W-bit words, MSB first.
// Optional feature: define MANCH_RX_ERRCNT_EN to add a saturating 8-bit
// err_cnt output that counts error pulses and is cleared only by rst.
module manch_rx #(
  parameter int OSR       = 8,
  parameter int DATA_W    = 8,
  parameter int LOCK_BITS = 4,
  parameter int POLARITY  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              enable,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              error,
  output logic              locked
`ifdef MANCH_RX_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int PH_SAT = (5 * OSR) / 4;
  localparam int PH_W   = $clog2(PH_SAT + 1);
  localparam int BC_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [PH_W-1:0] PH_SAT_V  = PH_W'(PH_SAT);
  localparam logic [PH_W-1:0] PH_MID_V  = PH_W'((3 * OSR) / 4);
  localparam logic [PH_W-1:0] PH_BND_V  = PH_W'(OSR / 4);
  localparam logic [3:0]      QUAL_LAST = 4'(LOCK_BITS - 1);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_W - 1);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q, sync3_q;
  logic [PH_W-1:0]   phase_q;
  logic [3:0]        qual_q;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [DATA_W-1:0] shreg_q;

  logic              edge_det, edge_fall, rx_bit, ph_sat, ph_late;
  logic              ev_mid, ev_glitch, ev_tmo, ev_lock, word_done, accept;
  logic              valid_d, err_d;
  logic [DATA_W-1:0] word_nxt;

  // Edge detection on the synchronised line; sync3_q is the previous sample.
  assign edge_det  = sync2_q ^ sync3_q;
  assign edge_fall = sync3_q & ~sync2_q;
  assign rx_bit    = (POLARITY != 0) ? ~edge_fall : edge_fall;

  // phase_q is 0 in the cycle after an accepted edge and saturates at PH_SAT.
  assign ph_sat  = (phase_q == PH_SAT_V);
  assign ph_late = (phase_q >= PH_MID_V);

  // LOCK events. An edge earlier than a quarter bit (including phase 0, which
  // only a glitch can produce) is treated as a glitch.
  assign ev_mid    = (state_q == LOCK) && edge_det && ph_late;
  assign ev_glitch = (state_q == LOCK) && edge_det && (phase_q < PH_BND_V);
  assign ev_tmo    = (state_q == LOCK) && !edge_det && ph_sat;
  assign ev_lock   = (state_q == HUNT) && edge_det && ph_late && (qual_q == QUAL_LAST);
  assign word_done = ev_mid && (bit_cnt_q == BIT_LAST);

  // HUNT restarts phase on every edge; LOCK only on mid-bit edges, so
  // bit-boundary edges leave the bit timing untouched.
  assign accept   = ((state_q == HUNT) && edge_det) || ev_mid || ev_glitch;
  assign word_nxt = (shreg_q << 1) | DATA_W'(rx_bit);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // Next-state logic: enable low wins over every event.
  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT:    if (ev_lock) state_d = LOCK;
        LOCK:    if (ev_glitch || ev_tmo) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Output decode: locked follows the state, pulses are registered next cycle.
  always_comb begin
    locked  = (state_q == LOCK);
    valid_d = enable && word_done;
    err_d   = enable && (ev_glitch || ev_tmo);
  end

  // Synchroniser, phase/qualification/bit counters and shift register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      phase_q   <= '0;
      qual_q    <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (!enable) begin
        phase_q   <= '0;
        qual_q    <= '0;
        bit_cnt_q <= '0;
      end else begin
        if (accept)       phase_q <= '0;
        else if (!ph_sat) phase_q <= phase_q + 1'b1;

        if (state_q == HUNT) begin
          bit_cnt_q <= '0;
          if (edge_det) qual_q <= (ph_late && !ev_lock) ? qual_q + 4'd1 : 4'd0;
          else if (ph_sat) qual_q <= '0;
        end else begin
          qual_q <= '0;
          if (ev_glitch || ev_tmo) begin
            bit_cnt_q <= '0;
          end else if (ev_mid) begin
            shreg_q   <= word_nxt;
            bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  // Output registers: dout holds between words, pulses last one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      error      <= 1'b0;
    end else begin
      dout_valid <= valid_d;
      error      <= err_d;
      if (valid_d) dout <= word_nxt;
    end
  end

`ifdef MANCH_RX_ERRCNT_EN
  // Saturating count of error pulses; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          err_cnt <= '0;
    else if (err_d && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
